// File: rtl/laser_pkg.sv
// Shared constants, FSM state encoding and window-clamp helpers for the laser scan controller.
package laser_pkg;

  localparam int unsigned NPTS_DEF = 40;
  localparam int unsigned GRID_W   = 4;
  localparam logic [GRID_W-1:0] COORD_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_CMP,
    S_FIN
  } state_t;

  // Widened add so a window near the top edge saturates at COORD_MAX instead of wrapping.
  function automatic logic [GRID_W-1:0] win_hi(input logic [GRID_W-1:0] c,
                                               input logic [GRID_W-1:0] w);
    logic [GRID_W:0] s;
    s = {1'b0, c} + {1'b0, w};
    return (s > {1'b0, COORD_MAX}) ? COORD_MAX : s[GRID_W-1:0];
  endfunction

  function automatic logic [GRID_W-1:0] win_lo(input logic [GRID_W-1:0] c,
                                               input logic [GRID_W-1:0] w);
    return (c >= w) ? c - w : '0;
  endfunction

endpackage

// File: rtl/laser_scan_ctrl_if.sv
// Point-request / hit-response handshake between the scan controller and the coverage evaluator.
interface laser_scan_ctrl_if;
  logic [3:0] CAND_X;
  logic [3:0] CAND_Y;
  logic [5:0] PT_IDX;
  logic       PT_VLD;
  logic       HIT_VLD;
  logic       HIT;

  modport master (output CAND_X, CAND_Y, PT_IDX, PT_VLD, input HIT_VLD, HIT);
  modport slave  (input CAND_X, CAND_Y, PT_IDX, PT_VLD, output HIT_VLD, HIT);
endinterface

// File: rtl/laser_win_gen.sv
// Candidate generator: latches clamped scan bounds on load and steps raster-wise on step.
module laser_win_gen
  import laser_pkg::*;
#(
  parameter int unsigned WIN = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic       step,
  input  logic       mode,
  input  logic [3:0] win_cx,
  input  logic [3:0] win_cy,
  output logic [3:0] cand_x,
  output logic [3:0] cand_y,
  output logic [3:0] lo_x,
  output logic [3:0] lo_y,
  output logic       last
);

  logic [3:0] hi_x, hi_y;
  logic [3:0] nlo_x, nlo_y, nhi_x, nhi_y;

  always_comb begin
    nlo_x = '0;
    nlo_y = '0;
    nhi_x = COORD_MAX;
    nhi_y = COORD_MAX;
    if (mode) begin
      nlo_x = win_lo(win_cx, 4'(WIN));
      nlo_y = win_lo(win_cy, 4'(WIN));
      nhi_x = win_hi(win_cx, 4'(WIN));
      nhi_y = win_hi(win_cy, 4'(WIN));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand_x <= '0;
      cand_y <= '0;
      lo_x   <= '0;
      lo_y   <= '0;
      hi_x   <= '0;
      hi_y   <= '0;
    end else if (load) begin
      lo_x   <= nlo_x;
      lo_y   <= nlo_y;
      hi_x   <= nhi_x;
      hi_y   <= nhi_y;
      cand_x <= nlo_x;
      cand_y <= nlo_y;
    end else if (step) begin
      if (cand_x == hi_x) begin
        cand_x <= lo_x;
        cand_y <= cand_y + 4'd1;
      end else begin
        cand_x <= cand_x + 4'd1;
      end
    end
  end

  assign last = (cand_x == hi_x) && (cand_y == hi_y);

endmodule

// File: rtl/laser_scan_ctrl.sv
// Scan controller: issues NPTS point queries per candidate center and keeps the best-covering one.
module laser_scan_ctrl
  import laser_pkg::*;
#(
  parameter int unsigned NPTS = NPTS_DEF,
  parameter int unsigned WIN  = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       MODE,
  input  logic [3:0] WIN_CX,
  input  logic [3:0] WIN_CY,
  laser_scan_ctrl_if.master evb,
  output logic [3:0] BEST_X,
  output logic [3:0] BEST_Y,
  output logic [5:0] BEST_CNT,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [5:0] NPTS6    = 6'(NPTS);
  localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);

  state_t     state;
  logic [5:0] rsp_cnt, hit_cnt, rsp_nxt;
  logic       acc, load, step, last, first;
  logic [3:0] cand_x, cand_y, lo_x, lo_y;

  laser_win_gen #(.WIN(WIN)) u_win (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load   (load),
    .step   (step),
    .mode   (MODE),
    .win_cx (WIN_CX),
    .win_cy (WIN_CY),
    .cand_x (cand_x),
    .cand_y (cand_y),
    .lo_x   (lo_x),
    .lo_y   (lo_y),
    .last   (last)
  );

  assign evb.CAND_X = cand_x;
  assign evb.CAND_Y = cand_y;
  assign load  = (state == S_IDLE) && START;
  assign step  = (state == S_CMP) && !last;
  assign first = (cand_x == lo_x) && (cand_y == lo_y);

  // Responses are only accepted while a candidate is in flight, and never beyond NPTS.
  always_comb begin
    acc     = evb.HIT_VLD && (rsp_cnt != NPTS6) && ((state == S_ISSUE) || (state == S_DRAIN));
    rsp_nxt = rsp_cnt + 6'(acc);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      rsp_cnt    <= '0;
      hit_cnt    <= '0;
      evb.PT_IDX <= '0;
      evb.PT_VLD <= 1'b0;
      BEST_X     <= '0;
      BEST_Y     <= '0;
      BEST_CNT   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (acc) begin
        rsp_cnt <= rsp_nxt;
        hit_cnt <= hit_cnt + 6'(evb.HIT);
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            state      <= S_ISSUE;
            BUSY       <= 1'b1;
            BEST_CNT   <= '0;
            rsp_cnt    <= '0;
            hit_cnt    <= '0;
            evb.PT_VLD <= 1'b1;
            evb.PT_IDX <= '0;
          end
        end
        S_ISSUE: begin
          if (evb.PT_IDX == LAST_IDX) begin
            evb.PT_VLD <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            evb.PT_IDX <= evb.PT_IDX + 6'd1;
          end
        end
        S_DRAIN: begin
          if (rsp_nxt == NPTS6) state <= S_CMP;
        end
        S_CMP: begin
          if (first || (hit_cnt >= BEST_CNT)) begin
            BEST_X   <= cand_x;
            BEST_Y   <= cand_y;
            BEST_CNT <= hit_cnt;
          end
          rsp_cnt <= '0;
          hit_cnt <= '0;
          if (last) begin
            state <= S_FIN;
            DONE  <= 1'b1;
          end else begin
            state      <= S_ISSUE;
            evb.PT_VLD <= 1'b1;
            evb.PT_IDX <= '0;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Directed-vector bench for laser_scan_ctrl with a fixed latency-1 evaluator model.
module tb_laser_scan_ctrl;

  localparam int P_NONE = 0;
  localparam int P_PEAK = 1;
  localparam int P_SUM  = 2;
  localparam int P_ANTI = 3;
  localparam int PERIOD = 42;

  typedef struct {
    logic       mode;
    logic [3:0] wcx;
    logic [3:0] wcy;
    int         pat;
    bit         tail;
    bit         idle_inj;
    int         kick;
    int         ncand;
    logic [3:0] ex;
    logic [3:0] ey;
    logic [5:0] ecnt;
  } vec_t;

  logic       CLK, RST_N, START, MODE;
  logic [3:0] WIN_CX, WIN_CY, BEST_X, BEST_Y;
  logic [5:0] BEST_CNT;
  logic       BUSY, DONE;

  laser_scan_ctrl_if evb();

  laser_scan_ctrl #(.NPTS(40), .WIN(4)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .MODE     (MODE),
    .WIN_CX   (WIN_CX),
    .WIN_CY   (WIN_CY),
    .evb      (evb),
    .BEST_X   (BEST_X),
    .BEST_Y   (BEST_Y),
    .BEST_CNT (BEST_CNT),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  int checks = 0;
  int errors = 0;

  int pat = P_NONE;
  bit tail_en = 0;
  bit inj = 0;
  int s_lx, s_hx, s_ly, s_hy, ex, ey, prev_idx, seq_err, n_issued;
  bit seq_started;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit hit_fn(input int p, input int x, input int y, input int idx);
    case (p)
      P_PEAK:  return ((x == 7) || (x == 9)) && (y == 3);
      P_SUM:   return idx < (x + y);
      P_ANTI:  return idx < (30 - x - y);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Evaluator: answers each issued point one cycle later, and tracks the candidate sequence.
  initial begin
    bit pv, tail_pend;
    int px, py, pi;
    tail_pend = 0;
    evb.HIT_VLD = 1'b0;
    evb.HIT = 1'b0;
    forever begin
      @(negedge CLK);
      pv = evb.PT_VLD;
      px = int'(evb.CAND_X);
      py = int'(evb.CAND_Y);
      pi = int'(evb.PT_IDX);
      if (pv) begin
        if (pi == 0) begin
          if (seq_started) begin
            if (ex == s_hx) begin
              ex = s_lx;
              ey++;
            end else begin
              ex++;
            end
            if (ey > s_hy) seq_err++;
          end
          seq_started = 1;
          n_issued++;
        end else if (pi != prev_idx + 1) begin
          seq_err++;
        end
        if (pi >= 40) seq_err++;
        if ((px != ex) || (py != ey)) seq_err++;
        prev_idx = pi;
      end
      @(posedge CLK);
      #1;
      evb.HIT_VLD = pv | inj | tail_pend;
      evb.HIT = (pv & hit_fn(pat, px, py, pi)) | inj | tail_pend;
      tail_pend = tail_en && pv && (pi == 39);
    end
  end

  task automatic seq_init(input vec_t v);
    int cx, cy;
    cx = int'(v.wcx);
    cy = int'(v.wcy);
    s_lx = v.mode ? ((cx >= 4) ? cx - 4 : 0) : 0;
    s_hx = v.mode ? ((cx + 4 > 15) ? 15 : cx + 4) : 15;
    s_ly = v.mode ? ((cy >= 4) ? cy - 4 : 0) : 0;
    s_hy = v.mode ? ((cy + 4 > 15) ? 15 : cy + 4) : 15;
    ex = s_lx;
    ey = s_ly;
    prev_idx = 0;
    seq_err = 0;
    n_issued = 0;
    seq_started = 0;
    pat = v.pat;
    tail_en = v.tail;
  endtask

  task automatic run_scan(input string tag, input vec_t v);
    int n;
    bit got;
    seq_init(v);
    if (v.idle_inj) begin
      @(negedge CLK);
      inj = 1;
      repeat (5) @(negedge CLK);
      inj = 0;
    end
    @(posedge CLK);
    #1;
    START = 1'b1;
    MODE = v.mode;
    WIN_CX = v.wcx;
    WIN_CY = v.wcy;
    @(posedge CLK);
    #1;
    START = 1'b0;
    MODE = ~v.mode;
    WIN_CX = ~v.wcx;
    WIN_CY = ~v.wcy;
    chk({tag, "_busy_start"}, BUSY, 1);
    n = 0;
    got = 0;
    while ((n < 12000) && !got) begin
      START = (v.kick > 0) && (n == v.kick);
      @(posedge CLK);
      #1;
      n++;
      if (DONE) got = 1;
    end
    START = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_cycles"}, n, v.ncand * PERIOD);
    chk({tag, "_best_x"}, BEST_X, v.ex);
    chk({tag, "_best_y"}, BEST_Y, v.ey);
    chk({tag, "_best_cnt"}, BEST_CNT, v.ecnt);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_ncand"}, n_issued, v.ncand);
    @(posedge CLK);
    #1;
    chk({tag, "_done_pulse"}, DONE, 0);
    chk({tag, "_busy_end"}, BUSY, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_best_hold"}, {BEST_X, BEST_Y, BEST_CNT}, {v.ex, v.ey, v.ecnt});
    tail_en = 0;
  endtask

  vec_t vecs[9];

  initial begin
    int w;
    vecs[0] = '{1'b0, 4'd0,  4'd0,  P_NONE, 1'b0, 1'b0, 0,   256, 4'd15, 4'd15, 6'd0};
    vecs[1] = '{1'b1, 4'd1,  4'd14, P_NONE, 1'b0, 1'b0, 0,   36,  4'd5,  4'd15, 6'd0};
    vecs[2] = '{1'b0, 4'd0,  4'd0,  P_PEAK, 1'b0, 1'b0, 0,   256, 4'd9,  4'd3,  6'd40};
    vecs[3] = '{1'b1, 4'd8,  4'd3,  P_PEAK, 1'b0, 1'b0, 0,   72,  4'd9,  4'd3,  6'd40};
    vecs[4] = '{1'b1, 4'd1,  4'd14, P_SUM,  1'b0, 1'b0, 0,   36,  4'd5,  4'd15, 6'd20};
    vecs[5] = '{1'b1, 4'd15, 4'd0,  P_SUM,  1'b0, 1'b0, 0,   25,  4'd15, 4'd4,  6'd19};
    vecs[6] = '{1'b1, 4'd5,  4'd5,  P_ANTI, 1'b0, 1'b0, 0,   81,  4'd1,  4'd1,  6'd28};
    vecs[7] = '{1'b1, 4'd8,  4'd3,  P_PEAK, 1'b1, 1'b1, 0,   72,  4'd9,  4'd3,  6'd40};
    vecs[8] = '{1'b1, 4'd8,  4'd3,  P_PEAK, 1'b0, 1'b0, 100, 72,  4'd9,  4'd3,  6'd40};

    RST_N = 1'b0;
    START = 1'b0;
    MODE = 1'b0;
    WIN_CX = '0;
    WIN_CY = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_pt_vld", evb.PT_VLD, 0);
    chk("reset_best_cnt", BEST_CNT, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 9; i++) run_scan($sformatf("vec%0d", i), vecs[i]);

    // Reset while candidate 5 is being issued, then a clean full scan.
    seq_init(vecs[2]);
    @(posedge CLK);
    #1;
    START = 1'b1;
    MODE = 1'b0;
    @(posedge CLK);
    #1;
    START = 1'b0;
    w = 0;
    while ((w < 1000) && !((n_issued == 6) && (evb.PT_IDX == 6'd10))) begin
      @(negedge CLK);
      w++;
    end
    chk("rst_reach_cand5", (w < 1000), 1);
    chk("rst_pre_cand_x", evb.CAND_X, 5);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pt_vld", evb.PT_VLD, 0);
    chk("rst_pt_idx", evb.PT_IDX, 0);
    chk("rst_cand", {evb.CAND_X, evb.CAND_Y}, 0);
    chk("rst_best", {BEST_X, BEST_Y, BEST_CNT}, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    run_scan("after_rst", vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
